switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter N, default 10, giving the number of switch bits.
REQ-002 The block SHALL have parameter DB_CYCLES, default 50000 (1 ms at 50 MHz), giving the debounce interval in clocks; the legal range is 2..2^20.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sw_raw, input, N bits: board switches, asynchronous to clk, and possibly bouncing.
REQ-006 The block SHALL have port clr_events, input, 1 bit: a synchronous pulse that clears all change flags.
REQ-007 The block SHALL have port switches, output, N bits: the debounced stable value; it drives the switches input of the data-memory block, which maps it at read address 0xC000_0000.
REQ-008 The block SHALL have port changed, output, N bits: sticky per-bit flags indicating that the stable value has toggled.
REQ-009 The block SHALL have port change_pulse, output, 1 bit: a single-cycle strobe indicating that any stable bit toggled.

Function
REQ-010 Each bit SHALL pass through a 2-flop synchronizer (sync1, then sync2) before any other logic uses it.
REQ-011 Each bit SHALL have an independent counter of width clog2(DB_CYCLES); bits SHALL NOT share counters or affect each other.
REQ-012 On any edge where sync2[i] == switches[i], counter[i] SHALL load 0.
REQ-013 On an edge where sync2[i] != switches[i] and counter[i] < DB_CYCLES-1, counter[i] SHALL increment by 1.
REQ-014 On an edge where sync2[i] != switches[i] and counter[i] == DB_CYCLES-1, switches[i] SHALL load sync2[i] and counter[i] SHALL load 0.
REQ-015 The counter SHALL NOT wrap: the maximum count is DB_CYCLES-1, and a mismatch at that count always causes the update in REQ-014.
REQ-016 Latency: if sw_raw[i] takes a new value that is stable from sampling edge 1 onward, switches[i] SHALL change at edge DB_CYCLES+2 and not before.
REQ-017 A raw level held for fewer than DB_CYCLES consecutive sync2 mismatch edges SHALL NOT change switches[i]; any return of sync2 to the stable value restarts the count from 0.
REQ-018 Per-bit state machine: STABLE (counter == 0, no mismatch) goes to COUNTING on a mismatch.
REQ-019 Per-bit state machine: COUNTING goes to STABLE on a match, with no update to switches[i].
REQ-020 Per-bit state machine: COUNTING at DB_CYCLES-1 with a mismatch goes to STABLE and updates switches[i].
REQ-021 changed[i] SHALL set on the same edge that switches[i] updates, and SHALL remain set until cleared.
REQ-022 clr_events high at an edge SHALL clear every changed bit that is not being set on that same edge; on a simultaneous set and clear, set wins.
REQ-023 change_pulse SHALL be high for exactly the one cycle following any edge on which at least one switches bit updated; simultaneous updates of several bits SHALL produce one pulse.
REQ-024 Consecutive updates on back-to-back edges SHALL keep change_pulse high for consecutive cycles.
REQ-025 All outputs SHALL be registered; there SHALL be no combinational path from sw_raw or clr_events to any output.

Reset
REQ-026 While reset is low, sync1, sync2, switches, all counters, changed and change_pulse SHALL be 0, independent of clk.
REQ-027 Reset asserted mid-count SHALL discard the count immediately, without waiting for a clock edge.
REQ-028 After reset deasserts, a raw bit held at 1 SHALL be treated as a normal 0->1 transition: per REQ-016 it updates switches and sets changed and change_pulse.

Verification (DB_CYCLES=4, N=10)
REQ-029 Reset exit: hold reset low with sw_raw=0x3FF, then release -> outputs read 0 until edge 6 after release; at edge 6 switches=0x3FF and changed=0x3FF; change_pulse is high for 1 cycle.
REQ-030 Clean toggle: after settling at 0x000, set sw_raw[3]=1 -> switches=0x008 at edge 6, changed[3]=1, and one change_pulse; no other bit moves.
REQ-031 Bounce: sw_raw[0] goes 1,0,1,0 at 2 cycles each, then is held at 1 -> switches[0] stays 0 throughout the bounce and rises 6 edges after the final 0->1; exactly one change_pulse.
REQ-032 Short glitch: sw_raw[5] high for 3 cycles, then 0 -> switches, changed and change_pulse are unchanged.
REQ-033 Clear race: clr_events pulses on the same edge that switches[7] updates -> changed[7]=1; a later lone clr_events -> changed=0x000.
REQ-034 Async reset mid-count: drop reset with counter[2]=2 between clock edges -> all outputs read 0 immediately; after release the count restarts from 0.

Source files
------------

// File: rtl/switch_debouncer.sv
// switch_debouncer
// Debounces N board switches. Each bit is synchronised through two flops,
// then must disagree with the current stable value for DB_CYCLES
// consecutive clocks before the stable value follows it. Toggles of the
// stable value raise sticky per-bit flags and a one-cycle strobe.
module switch_debouncer #(
  parameter int N         = 10,
  parameter int DB_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw_raw,
  input  logic         clr_events,
  output logic [N-1:0] switches,
  output logic [N-1:0] changed,
  output logic         change_pulse
);

  // DB_CYCLES-1 always fits in clog2(DB_CYCLES) bits for the legal range.
  localparam int            CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic {
    ST_STABLE,
    ST_COUNTING
  } bit_state_e;

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] upd;   // bits whose stable value flips on this edge

  // Two-flop synchroniser for the asynchronous switch inputs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse sync1/sync2
  // into a single stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_bit
    bit_state_e    state;
    logic [CW-1:0] cnt;
    logic          mismatch;

    assign mismatch = sync2[i] ^ switches[i];
    // The counter only reaches CNT_MAX while COUNTING, so this is the
    // "mismatch at the final count" condition.
    assign upd[i]   = mismatch && (cnt == CNT_MAX);

    // Per-bit debounce FSM: count consecutive mismatching edges, restart on
    // any match, and release an update after DB_CYCLES mismatches.
    // NOTE: the counters are ordinary flops (not a RAM), so they take the
    // async reset and a mid-count reset discards the count at once.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state <= ST_STABLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_STABLE: begin
            if (mismatch) begin
              state <= ST_COUNTING;
              cnt   <= CNT_ONE;
            end
          end
          ST_COUNTING: begin
            if (!mismatch || (cnt == CNT_MAX)) begin
              state <= ST_STABLE;
              cnt   <= '0;
            end else begin
              cnt   <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= ST_STABLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Registered outputs: stable value, sticky change flags (set beats clear),
  // and a strobe for the cycle after any update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      switches     <= '0;
      changed      <= '0;
      change_pulse <= 1'b0;
    end else begin
      switches     <= switches ^ upd;
      changed      <= (changed & ~{N{clr_events}}) | upd;
      change_pulse <= |upd;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
// Directed scenarios with literal expectations, then randomized switch
// activity, all cross-checked every cycle against a behavioural model.
module tb_switch_debouncer;

  localparam int N  = 10;
  localparam int DB = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] sw_raw;
  logic         clr_events;
  logic [N-1:0] switches;
  logic [N-1:0] changed;
  logic         change_pulse;

  int checks = 0;
  int passes = 0;

  switch_debouncer #(.N(N), .DB_CYCLES(DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_raw       (sw_raw),
    .clr_events   (clr_events),
    .switches     (switches),
    .changed      (changed),
    .change_pulse (change_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Raw samples reach the comparison point two edges later. A bit's stable
  // value follows the delayed sample once it has disagreed on DB
  // consecutive edges; any agreement (or an update) restarts the run.
  logic [N-1:0] hist [2];   // hist[0]: sampled last edge, hist[1]: two edges ago
  logic [N-1:0] m_stable;
  logic [N-1:0] m_changed;
  logic         m_pulse;
  int           run_len [N];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist[0] = '0; hist[1] = '0;
      m_stable = '0; m_changed = '0; m_pulse = 1'b0;
      for (int i = 0; i < N; i++) run_len[i] = 0;
    end else begin
      logic [N-1:0] flip;
      flip = '0;
      for (int i = 0; i < N; i++) begin
        if (hist[1][i] != m_stable[i]) begin
          run_len[i] = run_len[i] + 1;
          if (run_len[i] == DB) begin
            flip[i]    = 1'b1;
            run_len[i] = 0;
          end
        end else begin
          run_len[i] = 0;
        end
      end
      m_stable  = m_stable ^ flip;
      m_changed = (clr_events ? '0 : m_changed) | flip;
      m_pulse   = (flip != '0);
      hist[1]   = hist[0];
      hist[0]   = sw_raw;
    end
  end

  // Compare process: outputs against the model on every falling edge.
  always @(negedge clk) begin
    check("model.switches", 32'(switches), 32'(m_stable));
    check("model.changed",  32'(changed),  32'(m_changed));
    check("model.pulse",    32'(change_pulse), 32'(m_pulse));
  end

  // Advance n rising edges; return just after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int pulses;
  logic [N-1:0] snap_sw, snap_ch;

  initial begin
    reset      = 1'b0;
    sw_raw     = '1;
    clr_events = 1'b0;

    // Reset exit with all switches held high.
    step(3);
    check("rst.switches", 32'(switches), 32'h0);
    check("rst.changed",  32'(changed),  32'h0);
    check("rst.pulse",    32'(change_pulse), 32'h0);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check($sformatf("exit.switches@%0d", k), 32'(switches), (k == 6) ? 32'h3FF : 32'h0);
      check($sformatf("exit.changed@%0d", k),  32'(changed),  (k == 6) ? 32'h3FF : 32'h0);
      check($sformatf("exit.pulse@%0d", k),    32'(change_pulse), (k == 6) ? 32'h1 : 32'h0);
    end
    step(1);
    check("exit.pulse_drop", 32'(change_pulse), 32'h0);

    // Settle at zero and clear flags.
    sw_raw = '0;
    step(8);
    check("settle.switches", 32'(switches), 32'h0);
    clr_events = 1'b1;
    step(1);
    clr_events = 1'b0;
    check("settle.cleared", 32'(changed), 32'h0);

    // Clean toggle of bit 3.
    sw_raw = 10'h008;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check($sformatf("toggle.switches@%0d", k), 32'(switches), (k == 6) ? 32'h008 : 32'h0);
      check($sformatf("toggle.changed@%0d", k),  32'(changed),  (k == 6) ? 32'h008 : 32'h0);
      check($sformatf("toggle.pulse@%0d", k),    32'(change_pulse), (k == 6) ? 32'h1 : 32'h0);
    end
    step(1);
    check("toggle.pulse_drop", 32'(change_pulse), 32'h0);

    // Bounce on bit 0: 1,0,1,0 for two cycles each, then held high.
    pulses = 0;
    for (int b = 0; b < 4; b++) begin
      sw_raw[0] = (b % 2 == 0);
      repeat (2) begin
        step(1);
        if (change_pulse) pulses++;
        check("bounce.hold0", 32'(switches[0]), 32'h0);
      end
    end
    sw_raw[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      if (change_pulse) pulses++;
      if (k == 5) check("bounce.before", 32'(switches), 32'h008);
      if (k == 6) check("bounce.rise",   32'(switches), 32'h009);
    end
    check("bounce.pulses", 32'(pulses), 32'h1);

    // Short glitch on bit 5.
    snap_sw = switches;
    snap_ch = changed;
    pulses  = 0;
    sw_raw[5] = 1'b1;
    repeat (3) begin step(1); if (change_pulse) pulses++; end
    sw_raw[5] = 1'b0;
    repeat (10) begin step(1); if (change_pulse) pulses++; end
    check("glitch.switches", 32'(switches), 32'(snap_sw));
    check("glitch.changed",  32'(changed),  32'(snap_ch));
    check("glitch.pulses",   32'(pulses),   32'h0);

    // Clear racing the update of bit 7: set wins for bit 7 only.
    sw_raw[7] = 1'b1;
    step(5);
    clr_events = 1'b1;
    step(1);
    clr_events = 1'b0;
    check("race.switches", 32'(switches), 32'h089);
    check("race.changed",  32'(changed),  32'h080);
    step(2);
    clr_events = 1'b1;
    step(1);
    clr_events = 1'b0;
    check("race.cleared", 32'(changed), 32'h0);

    // Async reset with bit 2 mid-count.
    sw_raw[2] = 1'b1;
    step(4);
    #2 reset = 1'b0;
    #1;
    check("async.switches", 32'(switches), 32'h0);
    check("async.changed",  32'(changed),  32'h0);
    check("async.pulse",    32'(change_pulse), 32'h0);
    step(2);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check($sformatf("async.switches@%0d", k), 32'(switches), (k == 6) ? 32'h08D : 32'h0);
    end
    check("async.changed_after", 32'(changed), 32'h08D);

    // Randomized activity: sparse per-bit toggles give both short and long
    // runs; occasional clears.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] mask;
      mask = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) mask[i] = 1'b1;
      if ($urandom_range(0, 3) == 0) sw_raw = sw_raw ^ mask;
      clr_events = ($urandom_range(0, 15) == 0);
      step(1);
    end
    clr_events = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
